// File: rtl/i2s_rx_stereo.sv
// I2S slave receiver: oversamples BCLK/LRCLK/SDATA in the clk domain and emits
// one left/right Q1.15 pair per frame with a single-cycle sample_valid strobe.
module i2s_rx_stereo #(
    parameter int SYNC_STAGES = 2,
    parameter int SAMPLE_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       i2s_bclk,
    input  logic                       i2s_lrclk,
    input  logic                       i2s_sdata,
    output logic signed [SAMPLE_W-1:0] left_out,
    output logic signed [SAMPLE_W-1:0] right_out,
    output logic                       sample_valid,
    output logic                       locked,
    output logic                       frame_err
);

    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int CNT_W  = $clog2(SAMPLE_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SAMPLE_W);

    localparam logic [1:0] WAIT_REF  = 2'd0;
    localparam logic [1:0] WAIT_EDGE = 2'd1;
    localparam logic [1:0] RUN_L     = 2'd2;
    localparam logic [1:0] RUN_R     = 2'd3;

    // Bit 0 = BCLK, bit 1 = LRCLK, bit 2 = SDATA; all chains have equal depth
    // so data and word select stay aligned with the detected BCLK edge.
    logic [2:0]             pin_in;
    logic [2:0][SYNC_N-1:0] sync_q, sync_d;

    logic                bclk_s, lr_s, sd_s;
    logic                bclk_prev_q, bclk_prev_d;
    logic                bclk_rise;
    logic                lr_edge;

    logic [1:0]          state_q, state_d;
    logic                lr_prev_q, lr_prev_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SAMPLE_W-1:0] shift_q, shift_d;
    logic [SAMPLE_W-1:0] hold_q, hold_d;
    logic [SAMPLE_W-1:0] left_q, left_d;
    logic [SAMPLE_W-1:0] right_q, right_d;
    logic                valid_q, valid_d;
    logic                locked_q, locked_d;
    logic                err_q, err_d;

    logic [SAMPLE_W-1:0] shifted;
    logic [CNT_W-1:0]    n_bits;
    logic [SAMPLE_W-1:0] word;

    assign pin_in = {i2s_sdata, i2s_lrclk, i2s_bclk};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            sync_d[i] = {sync_q[i][SYNC_N-2:0], pin_in[i]};
        end
    end

    assign bclk_s    = sync_q[0][SYNC_N-1];
    assign lr_s      = sync_q[1][SYNC_N-1];
    assign sd_s      = sync_q[2][SYNC_N-1];
    assign bclk_rise = bclk_s & ~bclk_prev_q;
    assign lr_edge   = lr_s ^ lr_prev_q;

    // Word as it would look after taking the current bit; short words are
    // left-aligned so the captured bits land in the MSBs.
    always_comb begin
        if (cnt_q < CNT_FULL) begin
            shifted = {shift_q[SAMPLE_W-2:0], sd_s};
            n_bits  = cnt_q + CNT_W'(1);
        end else begin
            shifted = shift_q;
            n_bits  = cnt_q;
        end
        word = shifted << (CNT_FULL - n_bits);
    end

    always_comb begin
        bclk_prev_d = bclk_s;
        state_d     = state_q;
        lr_prev_d   = lr_prev_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        left_d      = left_q;
        right_d     = right_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        err_d       = err_q;

        if (!en) begin
            state_d  = WAIT_REF;
            locked_d = 1'b0;
            cnt_d    = '0;
        end else if (bclk_rise) begin
            lr_prev_d = lr_s;
            case (state_q)
                WAIT_REF: begin
                    state_d = WAIT_EDGE;
                end
                WAIT_EDGE: begin
                    if (lr_edge) begin
                        cnt_d   = '0;
                        shift_d = '0;
                        if (!lr_s) begin
                            state_d = RUN_L;
                        end
                    end
                end
                default: begin
                    if (lr_edge) begin
                        // The bit on this rise is the LSB of the slot just ended.
                        cnt_d   = '0;
                        shift_d = '0;
                        if (cnt_q == '0) begin
                            err_d    = 1'b1;
                            locked_d = 1'b0;
                            state_d  = WAIT_EDGE;
                        end else begin
                            if (n_bits < CNT_FULL) begin
                                err_d = 1'b1;
                            end
                            if (state_q == RUN_L) begin
                                hold_d  = word;
                                state_d = RUN_R;
                            end else begin
                                right_d  = word;
                                left_d   = hold_q;
                                valid_d  = 1'b1;
                                locked_d = 1'b1;
                                state_d  = RUN_L;
                            end
                        end
                    end else if (cnt_q < CNT_FULL) begin
                        shift_d = shifted;
                        cnt_d   = n_bits;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q      <= '0;
            bclk_prev_q <= 1'b0;
            state_q     <= WAIT_REF;
            lr_prev_q   <= 1'b0;
            cnt_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            bclk_prev_q <= bclk_prev_d;
            state_q     <= state_d;
            lr_prev_q   <= lr_prev_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
        end
    end

    assign left_out     = left_q;
    assign right_out    = right_q;
    assign sample_valid = valid_q;
    assign locked       = locked_q;
    assign frame_err    = err_q;

endmodule

// File: doc/i2s_rx_stereo.md
Name: i2s_rx_stereo

Overview:
- Upstream stage of the stereo IIR filter path.
- Oversamples an external I2S slave input (BCLK, LRCLK, SDATA) in the system clock domain and deserialises the first 16 bits of each channel slot, MSB first, Q1.15.
- Emits one left/right sample pair per frame with a single-cycle strobe. The strobe drives the filter cores' enable directly.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on each of the three I2S inputs (minimum 2).
- SAMPLE_W, 16, captured bits per channel; the filter path requires 16.

Ports:
- clk, input, 1, system clock; must be at least 4x the BCLK frequency.
- rst_n, input, 1, synchronous active-low reset.
- en, input, 1, receiver enable; when low, the receiver drops lock and emits nothing.
- i2s_bclk, input, 1, asynchronous bit clock.
- i2s_lrclk, input, 1, asynchronous word select; 0 = left, 1 = right.
- i2s_sdata, input, 1, asynchronous serial data.
- left_out, output, SAMPLE_W (signed), last complete left sample.
- right_out, output, SAMPLE_W (signed), last complete right sample.
- sample_valid, output, 1, one-clk pulse when left_out/right_out update.
- locked, output, 1, frame alignment acquired.
- frame_err, output, 1, sticky short-slot error flag.

Behaviour:
- Reset (rst_n=0 at a clk edge): left_out=0, right_out=0, sample_valid=0, locked=0, frame_err=0; synchronisers, shift register, bit counter and left holding register cleared; FSM goes to WAIT_REF.
- Inputs pass through SYNC_STAGES flops. bclk_rise is asserted for one clk when the synchronised BCLK goes 0->1. All capture logic acts only in clk cycles with bclk_rise=1.
- At each bclk_rise, the logic samples lr (synchronised LRCLK) and sd (synchronised SDATA). lr_prev holds lr from the previous bclk_rise.
- FSM states:
  - WAIT_REF: on the first bclk_rise, record lr_prev -> WAIT_EDGE.
  - WAIT_EDGE: on a bclk_rise with lr != lr_prev, clear the bit counter. If the new lr=0 -> RUN_L; otherwise stay in WAIT_EDGE. Alignment always starts on a left slot.
  - RUN_L / RUN_R:
    - If bit counter < SAMPLE_W: shift sd into the shift register (MSB first) and increment the counter.
    - Bits beyond SAMPLE_W are ignored; the counter saturates at SAMPLE_W. This supports 24/32-bit slots.
  - Slot end (lr != lr_prev): the bit sampled on this rise is the previous slot's LSB (I2S one-bit delay). Shift it if the counter < SAMPLE_W, then commit the word and clear the counter.
    - RUN_L -> RUN_R: commit into the left holding register.
    - RUN_R -> RUN_L: commit into right_out; copy the holding register to left_out; pulse sample_valid; set locked=1.
- Commit timing: left_out, right_out and sample_valid update at the clk edge ending the bclk_rise cycle. sample_valid is high for exactly that one following cycle. Pin-to-strobe latency is at most SYNC_STAGES+2 clk.
- Short slot (fewer than SAMPLE_W bits at commit, n>0):
  - Word committed left-aligned: captured bits in the MSBs, zeros below.
  - frame_err set; it is sticky and cleared only by rst_n.
  - Lock is not lost.
- Zero-length slot: no commit; frame_err set; FSM -> WAIT_EDGE; locked=0.
- en=0: FSM forced to WAIT_REF; locked=0; sample_valid=0.
  - left_out/right_out hold their last values.
  - frame_err is retained.
  - Capture resumes from WAIT_REF when en returns to 1.
- rst_n low mid-slot: partial word discarded; no sample_valid generated.
- The first sample_valid after reset or enable requires one complete left slot followed by one complete right slot.
- sample_valid can never occur in two consecutive clk cycles.

Test Plan:
- Reset then 64fs frames (16-bit data, 16 pad zeros) with L=0x4000, R=0xC000; clk = 8x BCLK -> first pulse after frame 2, left_out=0x4000, right_out=0xC000, locked=1, frame_err=0, exactly one pulse per frame.
- Exact 32fs frames, 3 pairs (0x7FFF/0x8000, 0x0001/0xFFFF, 0x1234/0xEDCB) -> three pulses; each pair appears in order; pulse spacing = 32 BCLK periods.
- Right slot truncated to 12 bits 0xABC -> right_out=0xABC0, frame_err=1; next normal frame still produces a pulse with frame_err held at 1.
- Reset deasserted mid right slot -> no pulse until a full left+right pair; first output equals the second frame's data.
- en dropped for 10 frames mid-stream -> no pulses, locked=0, outputs held; after re-enable, relock within 2 frames with correct data.
- Sweep clk:BCLK ratio at 4x and 13x with random data over 200 frames -> outputs match the reference model bit-exactly.
